// File: rtl/light_pkg.sv
// Shared types and mode helpers for the landing-light scheduler.
package light_pkg;

  typedef enum logic [1:0] {CALM = 2'b00, RIGHT = 2'b01, LEFT = 2'b10} mode_t;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_CHANGE} sched_state_t;

  // Auto-cycle order: CALM -> RIGHT -> LEFT -> CALM
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      CALM:    return RIGHT;
      RIGHT:   return LEFT;
      default: return CALM;
    endcase
  endfunction

  // Unused request code 11 falls back to CALM
  function automatic mode_t sanitize(input logic [1:0] req);
    case (req)
      2'b01:   return RIGHT;
      2'b10:   return LEFT;
      default: return CALM;
    endcase
  endfunction

endpackage

// File: rtl/light_mode_scheduler_if.sv
// Control/status bundle between the mode controller (master) and the scheduler (slave).
interface light_mode_scheduler_if #(
  parameter int unsigned DW = 4
);
  logic          auto_en;
  logic          pause;
  logic [1:0]    mode_req;
  logic [1:0]    mode;
  logic          tick_en;
  logic          light_clr;
  logic          changing;
  logic [DW-1:0] dwell_left;

  modport master (
    output auto_en, pause, mode_req,
    input  mode, tick_en, light_clr, changing, dwell_left
  );

  modport slave (
    input  auto_en, pause, mode_req,
    output mode, tick_en, light_clr, changing, dwell_left
  );
endinterface

// File: rtl/tick_gen.sv
// Prescaler producing a one-clock tick enable every TICK_DIV unpaused cycles.
module tick_gen #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic pause,
  output logic tick_en
);
  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!pause) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Pause masks the terminal count as well as freezing the counter
  assign tick_en = (cnt == CNT_LAST) && !pause;

endmodule

// File: rtl/light_mode_scheduler.sv
// Chooses the landing-light mode and applies changes on tick boundaries with a one-cycle clear.
module light_mode_scheduler
  import light_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 25_000_000,
  parameter int unsigned DWELL_TICKS = 8
) (
  input  logic             clk,
  input  logic             reset,
  light_mode_scheduler_if.slave bus
);
  localparam int unsigned DW = $clog2(DWELL_TICKS + 1);
  localparam logic [DW-1:0] DWELL_RELOAD = DW'(DWELL_TICKS - 1);

  sched_state_t  state;
  mode_t         mode_q;
  mode_t         tgt;
  logic          light_clr_q;
  logic          changing_q;
  logic [DW-1:0] dwell_q;
  logic          tick_en;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .pause   (bus.pause),
    .tick_en (tick_en)
  );

  // Mode the next tick would move to
  always_comb begin
    tgt = mode_q;
    if (bus.auto_en) begin
      tgt = (dwell_q == '0) ? next_mode(mode_q) : mode_q;
    end else begin
      tgt = sanitize(bus.mode_req);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_INIT;
      mode_q      <= CALM;
      light_clr_q <= 1'b1;
      changing_q  <= 1'b0;
      dwell_q     <= DWELL_RELOAD;
    end else begin
      if (!bus.auto_en) begin
        dwell_q <= DWELL_RELOAD;
      end
      case (state)
        S_INIT: begin
          light_clr_q <= 1'b0;
          state       <= S_RUN;
        end
        S_RUN: begin
          if (tick_en && (tgt != mode_q)) begin
            mode_q      <= tgt;
            light_clr_q <= 1'b1;
            changing_q  <= 1'b1;
            dwell_q     <= DWELL_RELOAD;
            state       <= S_CHANGE;
          end else if (tick_en && bus.auto_en) begin
            // Auto with no change implies dwell_q is non-zero
            dwell_q <= dwell_q - DW'(1);
          end
        end
        S_CHANGE: begin
          light_clr_q <= 1'b0;
          changing_q  <= 1'b0;
          state       <= S_RUN;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign bus.mode       = mode_q;
  assign bus.tick_en    = tick_en;
  assign bus.light_clr  = light_clr_q;
  assign bus.changing   = changing_q;
  assign bus.dwell_left = dwell_q;

endmodule

// File: tb/tb_light_mode_scheduler.sv
// Bench for light_mode_scheduler: directed table, corner sequences and random run vs. a reference model.
module tb_light_mode_scheduler;
  localparam int unsigned TD = 4;
  localparam int unsigned DWT = 3;
  localparam int unsigned DW = $clog2(DWT + 1);

  logic clk;
  logic reset;
  int n_cmp;
  int n_bad;

  light_mode_scheduler_if #(.DW(DW)) bus ();

  light_mode_scheduler #(.TICK_DIV(TD), .DWELL_TICKS(DWT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       au;
    logic       pz;
    logic [1:0] req;
    logic       chk;
    logic [1:0] mode;
    logic       tick;
    logic       clr;
    logic       chg;
    logic [1:0] dwell;
  } vec_t;

  vec_t vecs[20];

  // Reference model: position in the tick period, mode index 0..2, ticks spent in the mode
  int m_phase, m_mode, m_spent;
  bit m_clr, m_chg, m_init, m_valid;

  int       chg_k[$];
  int       chg_m[$];
  int       dw_tick[$];

  function automatic vec_t mk(input logic rst, au, pz, input logic [1:0] req, input logic chk,
                              input logic [1:0] mode, input logic tick, clr, chg,
                              input logic [1:0] dwell);
    vec_t v;
    v.rst = rst; v.au = au; v.pz = pz; v.req = req; v.chk = chk;
    v.mode = mode; v.tick = tick; v.clr = clr; v.chg = chg; v.dwell = dwell;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic p, input logic [1:0] q);
    @(negedge clk);
    reset = r;
    bus.auto_en = a;
    bus.pause = p;
    bus.mode_req = q;
    #1;
  endtask

  task automatic model_step();
    int tgt;
    bit tick;
    @(posedge clk);
    if (!reset) begin
      m_phase = 0; m_mode = 0; m_spent = 0;
      m_clr = 1'b1; m_chg = 1'b0; m_init = 1'b1; m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    tick = (m_phase == TD - 1) && !bus.pause;
    if (m_init) begin
      m_init = 1'b0;
      m_clr = 1'b0;
    end else if (m_chg) begin
      m_chg = 1'b0;
      m_clr = 1'b0;
    end else if (tick) begin
      if (bus.auto_en) tgt = (m_spent == DWT - 1) ? (m_mode + 1) % 3 : m_mode;
      else tgt = (bus.mode_req == 2'd3) ? 0 : int'(bus.mode_req);
      if (tgt != m_mode) begin
        m_mode = tgt; m_clr = 1'b1; m_chg = 1'b1; m_spent = 0;
      end else if (bus.auto_en) begin
        m_spent++;
      end
    end
    if (!bus.auto_en) m_spent = 0;
    if (!bus.pause) m_phase = (m_phase + 1) % TD;
  endtask

  task automatic check_model(input string tag);
    if (!m_valid) return;
    chk({tag, " mode"},  32'(bus.mode),       32'(m_mode));
    chk({tag, " tick"},  32'(bus.tick_en),    32'((m_phase == TD - 1) && !bus.pause));
    chk({tag, " clr"},   32'(bus.light_clr),  32'(m_clr));
    chk({tag, " chg"},   32'(bus.changing),   32'(m_chg));
    chk({tag, " dwell"}, 32'(bus.dwell_left), 32'(DWT - 1 - m_spent));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    m_valid = 1'b0; m_phase = 0; m_mode = 0; m_spent = 0;
    m_clr = 1'b0; m_chg = 1'b0; m_init = 1'b0;
    reset = 1'b0;
    bus.auto_en = 1'b0; bus.pause = 1'b0; bus.mode_req = 2'b00;

    // rst au pz req | chk mode tick clr chg dwell
    vecs[0]  = mk(0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 2'd0);
    vecs[1]  = mk(0, 0, 0, 2'd0, 1, 2'd0, 0, 1, 0, 2'd2);
    vecs[2]  = mk(0, 0, 0, 2'd0, 1, 2'd0, 0, 1, 0, 2'd2);
    vecs[3]  = mk(1, 0, 0, 2'd0, 1, 2'd0, 0, 1, 0, 2'd2);
    vecs[4]  = mk(1, 0, 0, 2'd0, 1, 2'd0, 0, 0, 0, 2'd2);
    vecs[5]  = mk(1, 0, 0, 2'd0, 1, 2'd0, 0, 0, 0, 2'd2);
    vecs[6]  = mk(1, 0, 0, 2'd0, 1, 2'd0, 1, 0, 0, 2'd2);
    vecs[7]  = mk(1, 0, 0, 2'd1, 1, 2'd0, 0, 0, 0, 2'd2);
    vecs[8]  = mk(1, 0, 0, 2'd1, 1, 2'd0, 0, 0, 0, 2'd2);
    vecs[9]  = mk(1, 0, 0, 2'd1, 1, 2'd0, 0, 0, 0, 2'd2);
    vecs[10] = mk(1, 0, 0, 2'd1, 1, 2'd0, 1, 0, 0, 2'd2);
    vecs[11] = mk(1, 0, 0, 2'd1, 1, 2'd1, 0, 1, 1, 2'd2);
    vecs[12] = mk(1, 0, 0, 2'd3, 1, 2'd1, 0, 0, 0, 2'd2);
    vecs[13] = mk(1, 0, 0, 2'd3, 1, 2'd1, 0, 0, 0, 2'd2);
    vecs[14] = mk(1, 0, 0, 2'd3, 1, 2'd1, 1, 0, 0, 2'd2);
    vecs[15] = mk(1, 0, 0, 2'd3, 1, 2'd0, 0, 1, 1, 2'd2);
    vecs[16] = mk(1, 0, 0, 2'd1, 1, 2'd0, 0, 0, 0, 2'd2);
    vecs[17] = mk(1, 0, 0, 2'd0, 1, 2'd0, 0, 0, 0, 2'd2);
    vecs[18] = mk(1, 0, 0, 2'd0, 1, 2'd0, 1, 0, 0, 2'd2);
    vecs[19] = mk(1, 0, 0, 2'd0, 1, 2'd0, 0, 0, 0, 2'd2);

    // Reset, first tick, manual change, request 11, short request pulse
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].au, vecs[i].pz, vecs[i].req);
      if (vecs[i].chk) begin
        chk($sformatf("v%0d mode", i),  32'(bus.mode),       32'(vecs[i].mode));
        chk($sformatf("v%0d tick", i),  32'(bus.tick_en),    32'(vecs[i].tick));
        chk($sformatf("v%0d clr", i),   32'(bus.light_clr),  32'(vecs[i].clr));
        chk($sformatf("v%0d chg", i),   32'(bus.changing),   32'(vecs[i].chg));
        chk($sformatf("v%0d dwell", i), 32'(bus.dwell_left), 32'(vecs[i].dwell));
      end
      model_step();
    end

    // Auto cycling from CALM starting at the beginning of a tick period
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, 1'b1, 1'b0, 2'd0);
      check_model("auto");
      if (bus.changing === 1'b1) begin
        chg_k.push_back(k);
        chg_m.push_back(int'(bus.mode));
      end
      if (bus.tick_en === 1'b1 && dw_tick.size() < 3) dw_tick.push_back(int'(bus.dwell_left));
      model_step();
    end
    chk("auto n_changes", 32'(chg_k.size()), 32'd3);
    if (chg_k.size() >= 3) begin
      chk("auto mode1", 32'(chg_m[0]), 32'd1);
      chk("auto mode2", 32'(chg_m[1]), 32'd2);
      chk("auto mode3", 32'(chg_m[2]), 32'd0);
      chk("auto gap1", 32'(chg_k[1] - chg_k[0]), 32'd12);
      chk("auto gap2", 32'(chg_k[2] - chg_k[1]), 32'd12);
    end
    chk("auto n_dwell", 32'(dw_tick.size()), 32'd3);
    if (dw_tick.size() >= 3) begin
      chk("auto dwell t1", 32'(dw_tick[0]), 32'd2);
      chk("auto dwell t2", 32'(dw_tick[1]), 32'd1);
      chk("auto dwell t3", 32'(dw_tick[2]), 32'd0);
    end

    // Pause for 10 cycles starting at count 2
    for (int k = 0; k < 8 && m_phase != 2; k++) begin
      drive(1'b1, 1'b0, 1'b0, 2'(m_mode));
      check_model("pre_pause");
      model_step();
    end
    chk("pause align", 32'(m_phase), 32'd2);
    begin
      int held;
      held = m_mode;
      for (int k = 0; k < 10; k++) begin
        drive(1'b1, 1'b0, 1'b1, 2'(held));
        chk("pause tick", 32'(bus.tick_en), 32'd0);
        chk("pause mode", 32'(bus.mode), 32'(held));
        model_step();
      end
      drive(1'b1, 1'b0, 1'b0, 2'(held));
      chk("resume tick0", 32'(bus.tick_en), 32'd0);
      model_step();
      drive(1'b1, 1'b0, 1'b0, 2'(held));
      chk("resume tick1", 32'(bus.tick_en), 32'd1);
      model_step();
    end

    // Reset asserted during a change
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 16 && !hit; k++) begin
        if (m_chg) begin
          drive(1'b0, 1'b0, 1'b0, 2'd2);
          chk("chg_rst changing", 32'(bus.changing), 32'd1);
          hit = 1'b1;
        end else begin
          drive(1'b1, 1'b0, 1'b0, 2'd2);
        end
        model_step();
      end
      chk("chg_rst found", 32'(hit), 32'd1);
      drive(1'b1, 1'b0, 1'b0, 2'd2);
      chk("chg_rst mode", 32'(bus.mode), 32'd0);
      chk("chg_rst clr", 32'(bus.light_clr), 32'd1);
      chk("chg_rst chg", 32'(bus.changing), 32'd0);
      chk("chg_rst tick_a", 32'(bus.tick_en), 32'd0);
      model_step();
      for (int k = 1; k < 4; k++) begin
        drive(1'b1, 1'b0, 1'b0, 2'd2);
        chk($sformatf("chg_rst tick_%0d", k), 32'(bus.tick_en), 32'(k == 3));
        model_step();
      end
    end

    // Random traffic against the reference model
    begin
      logic au;
      au = 1'b0;
      for (int k = 0; k < 1500; k++) begin
        if ($urandom_range(0, 39) == 0) au = ~au;
        drive(($urandom_range(0, 63) != 0), au, ($urandom_range(0, 5) == 0),
              2'($urandom_range(0, 3)));
        check_model("rand");
        model_step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
